// File: rtl/fgpr_arb_pkg.sv
// Shared types and round-robin helpers for FGPR read-port arbitration.
// Pure combinational helpers; no latency, no backpressure.
// The picker is sized for up to RR_MAX requesters so other arbiters can reuse it.
package fgpr_arb_pkg;

    localparam int FGPR_IDX_W = 5;
    localparam int RR_MAX     = 8;
    localparam int RR_IDX_W   = 3;

    typedef logic [FGPR_IDX_W-1:0] fgpr_idx_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid[n-1:0], searching cyclically upward from ptr (ptr < n).
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   valid,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input int unsigned         n);
        rr_pick_t   r;
        logic [3:0] s;
        r = '0;
        for (int k = 0; k < RR_MAX; k++) begin
            s = {1'b0, ptr} + 4'(k);
            if (s >= 4'(n)) s = s - 4'(n);
            if ((k < int'(n)) && !r.found && valid[s[RR_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = s[RR_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-wide round-robin picker with a registered search pointer.
// Pick is combinational (0 cycles); pointer moves on the edge after an enabled pick.
// No backpressure of its own; the caller gates pointer movement with advance.
module rr_arbiter
    import fgpr_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                srstn,
    input  logic [N-1:0]        valid,
    input  logic                advance,
    output logic                found,
    output logic [RR_IDX_W-1:0] idx,
    output logic [N-1:0]        grant
);

    logic [RR_IDX_W-1:0] ptr_q;
    logic [RR_MAX-1:0]   valid_ext;
    rr_pick_t            pick;

    always_comb begin
        valid_ext        = '0;
        valid_ext[N-1:0] = valid;
        pick             = rr_pick(valid_ext, ptr_q, N);
        found            = pick.found;
        idx              = pick.idx;
        grant            = pick.found ? (N'(1) << pick.idx) : '0;
    end

    // Next search starts just past the winner, wrapping N-1 -> 0.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            ptr_q <= '0;
        end else if (advance && pick.found) begin
            ptr_q <= (pick.idx == RR_IDX_W'(N - 1)) ? '0 : pick.idx + RR_IDX_W'(1);
        end
    end

endmodule

// File: rtl/fgpr_read_arbiter.sv
// Shares the single FGPR read port among NREQ requesters, round-robin with optional fixed priority for requester 0.
// Grant and FGPR read in the accept cycle; tagged response one cycle later, back-to-back capable.
// No response backpressure: requesters must sink rsp_valid_o the cycle it is asserted.
module fgpr_read_arbiter
    import fgpr_arb_pkg::*;
#(
    parameter int NREQ       = 3,
    parameter int XLEN       = 64,
    parameter int FIXED_PRIO = 0
) (
    input  logic                       clk_i,
    input  logic                       srstn_i,
    input  logic                       flush_i,
    input  logic [NREQ-1:0]            req_valid_i,
    input  logic [NREQ*FGPR_IDX_W-1:0] req_index_i,
    output logic [NREQ-1:0]            req_ready_o,
    output logic [NREQ-1:0]            rsp_valid_o,
    output logic [XLEN-1:0]            rsp_data_o,
    output logic                       fgpr_valid_o,
    output fgpr_idx_t                  fgpr_rs1index_o,
    input  logic [XLEN-1:0]            fgpr_rs1data_i
);

    logic [NREQ-1:0]     rr_valid;
    logic                rr_found;
    logic [RR_IDX_W-1:0] rr_idx;
    logic [NREQ-1:0]     rr_grant;
    logic                fixed_win;
    logic                win_found;
    logic [RR_IDX_W-1:0] win_idx;
    logic                grant_en;
    logic                rr_advance;
    fgpr_idx_t           sel_index;

    logic                rsp_vld_q;
    logic [RR_IDX_W-1:0] rsp_id_q;
    logic [XLEN-1:0]     rsp_data_q;

    // With fixed priority, requester 0 is kept out of the rotation entirely.
    always_comb begin
        rr_valid = req_valid_i;
        if (FIXED_PRIO != 0) rr_valid[0] = 1'b0;
    end

    rr_arbiter #(.N(NREQ)) u_rr (
        .clk     (clk_i),
        .srstn   (srstn_i),
        .valid   (rr_valid),
        .advance (rr_advance),
        .found   (rr_found),
        .idx     (rr_idx),
        .grant   (rr_grant)
    );

    always_comb begin
        fixed_win  = (FIXED_PRIO != 0) && req_valid_i[0];
        win_found  = fixed_win || rr_found;
        win_idx    = fixed_win ? '0 : rr_idx;
        grant_en   = win_found && !flush_i && srstn_i;
        rr_advance = grant_en && !fixed_win;

        sel_index = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == RR_IDX_W'(i)) sel_index = req_index_i[i*FGPR_IDX_W +: FGPR_IDX_W];
        end

        req_ready_o     = '0;
        fgpr_valid_o    = 1'b0;
        fgpr_rs1index_o = '0;
        if (grant_en) begin
            req_ready_o     = fixed_win ? NREQ'(1) : rr_grant;
            fgpr_valid_o    = 1'b1;
            fgpr_rs1index_o = sel_index;
        end
    end

    // Data is held when nothing is granted so rsp_data_o keeps its last value.
    always_ff @(posedge clk_i) begin
        if (!srstn_i) begin
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            rsp_vld_q <= grant_en;
            if (grant_en) begin
                rsp_id_q   <= win_idx;
                rsp_data_q <= fgpr_rs1data_i;
            end
        end
    end

    assign rsp_valid_o = rsp_vld_q ? (NREQ'(1) << rsp_id_q) : '0;
    assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_fgpr_read_arbiter.sv
// Bench for fgpr_read_arbiter: a pure round-robin and a fixed-priority instance share stimulus,
// checked by directed vectors and a cycle-level reference model under random traffic.
module tb_fgpr_read_arbiter;

    logic        clk = 1'b0;
    logic        srstn = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [14:0] req_index = '0;

    logic [2:0]  ready  [2];
    logic [2:0]  rsp_v  [2];
    logic [63:0] rsp_d  [2];
    logic        fvld   [2];
    logic [4:0]  fidx   [2];
    logic [63:0] fdata  [2];

    logic [63:0] regs [32];

    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    assign fdata[0] = regs[fidx[0]];
    assign fdata[1] = regs[fidx[1]];

    fgpr_read_arbiter #(.NREQ(3), .XLEN(64), .FIXED_PRIO(0)) dut_rr (
        .clk_i(clk), .srstn_i(srstn), .flush_i(flush),
        .req_valid_i(req_valid), .req_index_i(req_index), .req_ready_o(ready[0]),
        .rsp_valid_o(rsp_v[0]), .rsp_data_o(rsp_d[0]),
        .fgpr_valid_o(fvld[0]), .fgpr_rs1index_o(fidx[0]), .fgpr_rs1data_i(fdata[0])
    );

    fgpr_read_arbiter #(.NREQ(3), .XLEN(64), .FIXED_PRIO(1)) dut_fp (
        .clk_i(clk), .srstn_i(srstn), .flush_i(flush),
        .req_valid_i(req_valid), .req_index_i(req_index), .req_ready_o(ready[1]),
        .rsp_valid_o(rsp_v[1]), .rsp_data_o(rsp_d[1]),
        .fgpr_valid_o(fvld[1]), .fgpr_rs1index_o(fidx[1]), .fgpr_rs1data_i(fdata[1])
    );

    // Reference model state per instance (0 = round-robin, 1 = fixed priority).
    int          m_ptr [2];
    logic [2:0]  m_rv  [2];
    logic [63:0] m_rd  [2];
    int          m_win [2];
    bit          m_g   [2];
    logic        cur_rstn;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    endtask

    // Spec rule: requester 0 pre-empts when fixed priority; otherwise first valid cyclically from ptr.
    function automatic int pick(input logic [2:0] v, input int ptr, input bit fp);
        if (fp && v[0]) return 0;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (ptr + k) % 3;
            if (!(fp && i == 0) && v[i]) return i;
        end
        return -1;
    endfunction

    task automatic apply(input logic rstn, input logic fl, input logic [2:0] v, input logic [14:0] ix);
        logic [2:0] er;
        logic [4:0] ei;
        srstn = rstn; flush = fl; req_valid = v; req_index = ix; cur_rstn = rstn;
        #1;
        for (int k = 0; k < 2; k++) begin
            m_win[k] = pick(v, m_ptr[k], k == 1);
            m_g[k]   = rstn && !fl && (m_win[k] >= 0);
            er = m_g[k] ? (3'b001 << m_win[k]) : 3'b000;
            ei = m_g[k] ? ix[m_win[k]*5 +: 5] : 5'd0;
            chk($sformatf("ready%0d", k), 64'(ready[k]), 64'(er));
            chk($sformatf("fvld%0d", k), 64'(fvld[k]), 64'(m_g[k]));
            chk($sformatf("fidx%0d", k), 64'(fidx[k]), 64'(ei));
            chk($sformatf("rsp_valid%0d", k), 64'(rsp_v[k]), 64'(m_rv[k]));
            chk($sformatf("rsp_data%0d", k), rsp_d[k], m_rd[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!cur_rstn) begin
                m_ptr[k] = 0; m_rv[k] = '0; m_rd[k] = '0;
            end else begin
                m_rv[k] = m_g[k] ? (3'b001 << m_win[k]) : 3'b000;
                if (m_g[k]) m_rd[k] = regs[req_index[m_win[k]*5 +: 5]];
                if (m_g[k] && !(k == 1 && m_win[k] == 0)) m_ptr[k] = (m_win[k] + 1) % 3;
            end
        end
        #1;
    endtask

    typedef struct {
        logic       rstn;
        logic       fl;
        logic [2:0] v;
        logic [2:0] ex_ready;
        logic [2:0] ex_rsp;
    } vec_t;

    function automatic vec_t mk(input logic rstn, input logic fl, input logic [2:0] v,
                                input logic [2:0] er, input logic [2:0] es);
        vec_t t;
        t.rstn = rstn; t.fl = fl; t.v = v; t.ex_ready = er; t.ex_rsp = es;
        return t;
    endfunction

    vec_t        tab [25];
    logic [14:0] dix;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = {32'hA5A5_0000 | 32'(i), $urandom};
        regs[7] = 64'h4000_0000_0000_0001;
        dix = {5'd9, 5'd7, 5'd3};

        // reset with everything requesting
        tab[0]  = mk(0, 0, 3'b111, 3'b000, 3'b000);
        tab[1]  = mk(0, 0, 3'b111, 3'b000, 3'b000);
        tab[2]  = mk(0, 0, 3'b111, 3'b000, 3'b000);
        tab[3]  = mk(1, 0, 3'b111, 3'b001, 3'b000);
        // single read of f7 by requester 1
        tab[4]  = mk(1, 0, 3'b010, 3'b010, 3'b001);
        tab[5]  = mk(1, 0, 3'b000, 3'b000, 3'b010);
        // fairness from a fresh pointer
        tab[6]  = mk(0, 0, 3'b000, 3'b000, 3'b000);
        tab[7]  = mk(1, 0, 3'b111, 3'b001, 3'b000);
        tab[8]  = mk(1, 0, 3'b111, 3'b010, 3'b001);
        tab[9]  = mk(1, 0, 3'b111, 3'b100, 3'b010);
        tab[10] = mk(1, 0, 3'b111, 3'b001, 3'b100);
        tab[11] = mk(1, 0, 3'b111, 3'b010, 3'b001);
        tab[12] = mk(1, 0, 3'b111, 3'b100, 3'b010);
        tab[13] = mk(1, 0, 3'b000, 3'b000, 3'b100);
        // flush after a grant to requester 2
        tab[14] = mk(1, 0, 3'b100, 3'b100, 3'b000);
        tab[15] = mk(1, 1, 3'b001, 3'b000, 3'b100);
        tab[16] = mk(1, 0, 3'b001, 3'b001, 3'b000);
        tab[17] = mk(1, 0, 3'b000, 3'b000, 3'b001);
        // withdrawn request from requester 1
        tab[18] = mk(0, 0, 3'b000, 3'b000, 3'b000);
        tab[19] = mk(1, 0, 3'b011, 3'b001, 3'b000);
        tab[20] = mk(1, 0, 3'b000, 3'b000, 3'b001);
        tab[21] = mk(1, 0, 3'b000, 3'b000, 3'b000);
        // reset drops a pending response
        tab[22] = mk(1, 0, 3'b100, 3'b100, 3'b000);
        tab[23] = mk(0, 0, 3'b000, 3'b000, 3'b100);
        tab[24] = mk(1, 0, 3'b000, 3'b000, 3'b000);

        cur_rstn = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_rv[k] = '0; m_rd[k] = '0;
        end

        for (int i = 0; i < 25; i++) begin
            apply(tab[i].rstn, tab[i].fl, tab[i].v, dix);
            chk($sformatf("vec%0d_ready", i), 64'(ready[0]), 64'(tab[i].ex_ready));
            chk($sformatf("vec%0d_rsp", i), 64'(rsp_v[0]), 64'(tab[i].ex_rsp));
            if (i == 5) chk("single_read_data", rsp_d[0], 64'h4000_0000_0000_0001);
            tick();
        end

        // fixed priority: requester 0 holds off requester 2 until it drops
        apply(0, 0, 3'b000, dix); tick();
        for (int c = 0; c < 3; c++) begin
            apply(1, 0, 3'b101, dix);
            chk($sformatf("fp_hold%0d", c), 64'(ready[1]), 64'(3'b001));
            if (c > 0) chk($sformatf("fp_rsp%0d", c), 64'(rsp_v[1]), 64'(3'b001));
            tick();
        end
        apply(1, 0, 3'b100, dix);
        chk("fp_req2_after", 64'(ready[1]), 64'(3'b100));
        tick();
        apply(1, 0, 3'b000, dix);
        chk("fp_req2_rsp", 64'(rsp_v[1]), 64'(3'b100));
        chk("fp_req2_data", rsp_d[1], regs[9]);
        tick();

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            apply($urandom_range(0, 49) != 0, $urandom_range(0, 9) == 0,
                  3'($urandom), 15'($urandom));
            tick();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
